// File: rtl/h_gate_pass_sequencer_pkg.sv
// Shared types and constants for the Hadamard pass sequencer and its h_gate datapath.
// Amplitudes are S3.4 fixed point. The state vector holds 2^N_QUBITS amplitudes.
package h_gate_pass_sequencer_pkg;

    localparam int N_QUBITS    = 3;
    localparam int H_LATENCY   = 4;
    localparam int ADDR_W      = N_QUBITS;
    localparam int QIDX_W      = $clog2(N_QUBITS) + 1;
    localparam int N_PAIRS     = 1 << (N_QUBITS - 1);
    localparam int K_W         = (N_QUBITS > 1) ? N_QUBITS - 1 : 1;

    localparam int TOTAL_WIDTH = 8;
    localparam int FRAC_WIDTH  = 4;
    localparam int ADD_WIDTH   = TOTAL_WIDTH + 1;
    localparam int MUL_WIDTH   = ADD_WIDTH + TOTAL_WIDTH;

    typedef logic signed [TOTAL_WIDTH-1:0] amp_t;
    typedef logic signed [ADD_WIDTH-1:0]   sum_t;
    typedef logic signed [MUL_WIDTH-1:0]   prod_t;
    typedef logic [ADDR_W-1:0]             addr_t;
    typedef logic [QIDX_W-1:0]             qidx_t;

    // 1/sqrt(2) in S3.4 (0.7071 * 16 = 11.3, truncated)
    localparam amp_t INV_SQRT2 = 8'sd11;

    localparam qidx_t          N_QUBITS_IDX = qidx_t'(N_QUBITS);
    localparam logic [K_W-1:0] K_LAST       = K_W'(N_PAIRS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    typedef struct packed {
        logic  vld;
        addr_t a0;
        addr_t a1;
    } pair_tag_t;

    // Spread the pair index k over every address bit except bit t, leaving bit t at 0.
    function automatic addr_t insert_zero(input logic [K_W-1:0] k, input qidx_t t);
        addr_t k_ext;
        addr_t res;
        int    src;
        k_ext = addr_t'(k);
        res   = '0;
        src   = 0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (b != int'(t)) begin
                res[b] = k_ext[src];
                src++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/h_gate_pass_sequencer_if.sv
// State-vector register-file port: two combinational read ports and a dual-address write.
// The master (sequencer) drives addresses and write data; the slave (register file) returns read data.
interface h_gate_pass_sequencer_if;
    import h_gate_pass_sequencer_pkg::*;

    addr_t rd_addr0;
    addr_t rd_addr1;
    amp_t  rd0_r;
    amp_t  rd0_i;
    amp_t  rd1_r;
    amp_t  rd1_i;
    logic  wr_en;
    addr_t wr_addr0;
    addr_t wr_addr1;
    amp_t  wr0_r;
    amp_t  wr0_i;
    amp_t  wr1_r;
    amp_t  wr1_i;

    modport master (
        output rd_addr0, rd_addr1,
        input  rd0_r, rd0_i, rd1_r, rd1_i,
        output wr_en, wr_addr0, wr_addr1,
        output wr0_r, wr0_i, wr1_r, wr1_i
    );

    modport slave (
        input  rd_addr0, rd_addr1,
        output rd0_r, rd0_i, rd1_r, rd1_i,
        input  wr_en, wr_addr0, wr_addr1,
        input  wr0_r, wr0_i, wr1_r, wr1_i
    );

endinterface

// File: rtl/h_gate_pass_sequencer_h_gate.sv
// h_gate_simplified: fixed-latency Hadamard butterfly on one complex amplitude pair.
// alpha = (a+b)/sqrt2, beta = (a-b)/sqrt2 in S3.4; arithmetic shift, truncate, no saturation.
module h_gate_simplified
    import h_gate_pass_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  amp_t a_r_i,
    input  amp_t a_i_i,
    input  amp_t b_r_i,
    input  amp_t b_i_i,
    output amp_t alpha_r_o,
    output amp_t alpha_i_o,
    output amp_t beta_r_o,
    output amp_t beta_i_o
);

    function automatic prod_t scale(input sum_t s);
        return prod_t'(s) * prod_t'(INV_SQRT2);
    endfunction

    function automatic amp_t shift_trunc(input prod_t p);
        prod_t sh;
        sh = p >>> FRAC_WIDTH;
        return amp_t'(sh[TOTAL_WIDTH-1:0]);
    endfunction

    amp_t  a_r_q, a_i_q, b_r_q, b_i_q;
    sum_t  s_r_q, s_i_q, d_r_q, d_i_q;
    prod_t ps_r_q, ps_i_q, pd_r_q, pd_i_q;
    amp_t  al_r_q, al_i_q, be_r_q, be_i_q;

    // Four register stages: capture, add/sub, multiply, shift/truncate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r_q  <= '0;  a_i_q  <= '0;  b_r_q  <= '0;  b_i_q  <= '0;
            s_r_q  <= '0;  s_i_q  <= '0;  d_r_q  <= '0;  d_i_q  <= '0;
            ps_r_q <= '0;  ps_i_q <= '0;  pd_r_q <= '0;  pd_i_q <= '0;
            al_r_q <= '0;  al_i_q <= '0;  be_r_q <= '0;  be_i_q <= '0;
        end else begin
            a_r_q  <= a_r_i;
            a_i_q  <= a_i_i;
            b_r_q  <= b_r_i;
            b_i_q  <= b_i_i;
            s_r_q  <= sum_t'(a_r_q) + sum_t'(b_r_q);
            s_i_q  <= sum_t'(a_i_q) + sum_t'(b_i_q);
            d_r_q  <= sum_t'(a_r_q) - sum_t'(b_r_q);
            d_i_q  <= sum_t'(a_i_q) - sum_t'(b_i_q);
            ps_r_q <= scale(s_r_q);
            ps_i_q <= scale(s_i_q);
            pd_r_q <= scale(d_r_q);
            pd_i_q <= scale(d_i_q);
            al_r_q <= shift_trunc(ps_r_q);
            al_i_q <= shift_trunc(ps_i_q);
            be_r_q <= shift_trunc(pd_r_q);
            be_i_q <= shift_trunc(pd_i_q);
        end
    end

    assign alpha_r_o = al_r_q;
    assign alpha_i_o = al_i_q;
    assign beta_r_o  = be_r_q;
    assign beta_i_o  = be_i_q;

endmodule

// File: rtl/h_gate_pass_sequencer.sv
// Sequences one Hadamard pass over the state vector: issues one amplitude pair per cycle
// into h_gate_simplified and writes both results back after its fixed latency.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for start; target sampled here
//  ST_ISSUE | reading pair k and feeding the h_gate, k = 0..N_PAIRS-1
//  ST_DRAIN | all pairs issued, waiting for outstanding writes
//  ST_DONE  | one-cycle done pulse
//  ST_ERR   | invalid target: one-cycle done+err pulse, no memory access
module h_gate_pass_sequencer
    import h_gate_pass_sequencer_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  qidx_t                          target_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    h_gate_pass_sequencer_if.master        mem
);

    seq_state_e                   state_q;
    logic [K_W-1:0]               k_q;
    qidx_t                        target_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         err_q;
    pair_tag_t [H_LATENCY-1:0]    tag_q;

    logic  issue;
    logic  drain_empty;
    addr_t addr0;
    addr_t addr1;

    assign issue = (state_q == ST_ISSUE);
    assign addr0 = issue ? insert_zero(k_q, target_q) : '0;
    assign addr1 = issue ? (insert_zero(k_q, target_q) | (addr_t'(1) << target_q)) : '0;

    // The last stage is the one writing this cycle, so only earlier stages hold pending work.
    always_comb begin
        drain_empty = 1'b1;
        for (int s = 0; s < H_LATENCY - 1; s++) begin
            if (tag_q[s].vld) drain_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        target_q <= target_i;
                        k_q      <= '0;
                        if (target_i < N_QUBITS_IDX) begin
                            state_q <= ST_ISSUE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == K_LAST) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= {issue, addr0, addr1};
            for (int s = 1; s < H_LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    h_gate_simplified u_h_gate (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_r_i     (mem.rd0_r),
        .a_i_i     (mem.rd0_i),
        .b_r_i     (mem.rd1_r),
        .b_i_i     (mem.rd1_i),
        .alpha_r_o (mem.wr0_r),
        .alpha_i_o (mem.wr0_i),
        .beta_r_o  (mem.wr1_r),
        .beta_i_o  (mem.wr1_i)
    );

    assign mem.rd_addr0 = addr0;
    assign mem.rd_addr1 = addr1;
    assign mem.wr_en    = tag_q[H_LATENCY-1].vld;
    assign mem.wr_addr0 = tag_q[H_LATENCY-1].a0;
    assign mem.wr_addr1 = tag_q[H_LATENCY-1].a1;

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_h_gate_pass_sequencer.sv
// Bench for h_gate_pass_sequencer: directed vector table, hand-written corner sequences
// and random passes checked against a whole-state-vector Hadamard reference model.
module tb_h_gate_pass_sequencer;
    import h_gate_pass_sequencer_pkg::*;

    localparam int NQ  = 3;
    localparam int NA  = 8;
    localparam int NP  = 4;
    localparam int LAT = 4;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  start;
    qidx_t target;
    logic  busy_o, done_o, err_o;

    logic  ld_we;
    addr_t ld_addr;
    amp_t  ld_r, ld_i;
    amp_t  mem_r [NA];
    amp_t  mem_i [NA];

    int exp_r [NA];
    int exp_i [NA];

    int vectors;
    int miscompares;

    typedef struct {
        int tgt;
        int hot;
        int val;
        int lo;
        int hi;
        int exp_lo;
        int exp_hi;
        int exp_err;
    } vec_t;
    vec_t vt [8];

    h_gate_pass_sequencer_if ifc ();

    h_gate_pass_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .target_i (target),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .mem      (ifc)
    );

    always #5 clk = ~clk;

    always_comb begin
        ifc.rd0_r = mem_r[ifc.rd_addr0];
        ifc.rd0_i = mem_i[ifc.rd_addr0];
        ifc.rd1_r = mem_r[ifc.rd_addr1];
        ifc.rd1_i = mem_i[ifc.rd_addr1];
    end

    always @(posedge clk) begin
        if (ld_we) begin
            mem_r[ld_addr] <= ld_r;
            mem_i[ld_addr] <= ld_i;
        end else if (ifc.wr_en) begin
            mem_r[ifc.wr_addr0] <= ifc.wr0_r;
            mem_i[ifc.wr_addr0] <= ifc.wr0_i;
            mem_r[ifc.wr_addr1] <= ifc.wr1_r;
            mem_i[ifc.wr_addr1] <= ifc.wr1_i;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // (s * 1/sqrt2) in S3.4: multiply by 11, arithmetic shift by 4, keep low 8 bits.
    function automatic int hq(input int s);
        int p;
        logic signed [7:0] r;
        p = (s * 11) >>> 4;
        r = p[7:0];
        return int'(r);
    endfunction

    function automatic void model_pass(input int t);
        int a_r, a_i, b_r, b_i;
        if (t >= NQ) return;
        for (int i = 0; i < NA; i++) begin
            if (((i >> t) & 1) == 0) begin
                a_r = exp_r[i];  a_i = exp_i[i];
                b_r = exp_r[i + (1 << t)];  b_i = exp_i[i + (1 << t)];
                exp_r[i] = hq(a_r + b_r);
                exp_i[i] = hq(a_i + b_i);
                exp_r[i + (1 << t)] = hq(a_r - b_r);
                exp_i[i + (1 << t)] = hq(a_i - b_i);
            end
        end
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < NA; i++) begin
            exp_r[i] = 0;
            exp_i[i] = 0;
        end
    endfunction

    task automatic load_mem();
        for (int i = 0; i < NA; i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = addr_t'(i);
            ld_r    = amp_t'(exp_r[i]);
            ld_i    = amp_t'(exp_i[i]);
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < NA; i++) begin
            check($sformatf("%s amp_r[%0d]", tag, i), int'(mem_r[i]), exp_r[i]);
            check($sformatf("%s amp_i[%0d]", tag, i), int'(mem_i[i]), exp_i[i]);
        end
    endtask

    task automatic wait_done(input int n0, output int lat);
        int n;
        n = n0;
        while (!done_o && n < n0 + 40) begin
            @(posedge clk); #1;
            n++;
        end
        lat = done_o ? n : -1;
    endtask

    // Runs one pass, checking the cycle-by-cycle schedule; returns in IDLE one cycle after done.
    task automatic run_pass(input int t, output int lat, output int err_seen);
        int  lo [$];
        bit  valid;
        int  exp_wr;
        valid = (t < NQ);
        for (int i = 0; i < NA; i++) begin
            if (valid && ((i >> t) & 1) == 0) lo.push_back(i);
        end
        lat = -1;
        err_seen = 0;
        @(negedge clk);
        start  = 1'b1;
        target = qidx_t'(t);
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            check("busy", int'(busy_o), int'(valid && n < NP + LAT));
            exp_wr = int'(valid && n >= LAT && n < NP + LAT);
            check("wr_en", int'(ifc.wr_en), exp_wr);
            if (valid && n < NP) begin
                check("rd_addr0", int'(ifc.rd_addr0), lo[n]);
                check("rd_addr1", int'(ifc.rd_addr1), lo[n] + (1 << t));
            end else begin
                check("rd_addr0 idle", int'(ifc.rd_addr0), 0);
            end
            if (exp_wr != 0 && ifc.wr_en) begin
                check("wr_addr0", int'(ifc.wr_addr0), lo[n - LAT]);
                check("wr_addr1", int'(ifc.wr_addr1), lo[n - LAT] + (1 << t));
            end
            if (done_o) begin
                lat = n;
                err_seen = int'(err_o);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},     int'(busy_o), 0);
        check({tag, " done"},     int'(done_o), 0);
        check({tag, " err"},      int'(err_o), 0);
        check({tag, " wr_en"},    int'(ifc.wr_en), 0);
        check({tag, " rd_addr0"}, int'(ifc.rd_addr0), 0);
        check({tag, " rd_addr1"}, int'(ifc.rd_addr1), 0);
        check({tag, " wr_addr0"}, int'(ifc.wr_addr0), 0);
        check({tag, " wr_addr1"}, int'(ifc.wr_addr1), 0);
        check({tag, " wr0_r"},    int'(ifc.wr0_r), 0);
        check({tag, " wr1_i"},    int'(ifc.wr1_i), 0);
    endtask

    initial begin
        int lat, errv, t;
        rst_n = 1'b0; start = 1'b0; target = '0;
        ld_we = 1'b0; ld_addr = '0; ld_r = '0; ld_i = '0;
        vectors = 0; miscompares = 0;

        //          tgt hot  val  lo hi  exp_lo exp_hi err
        vt[0] = '{0,   0,   16,  0, 1,  11,    11,    0};
        vt[1] = '{2,   4,   16,  0, 4,  11,   -11,    0};
        vt[2] = '{1,   2,   16,  0, 2,  11,   -11,    0};
        vt[3] = '{0,   1,  -16,  0, 1, -11,    11,    0};
        vt[4] = '{3,   0,   16,  0, 1,  16,     0,    1};
        vt[5] = '{7,   5,    5,  4, 5,   0,     5,    1};
        vt[6] = '{1,   7,  127,  5, 7,  87,   -88,    0};
        vt[7] = '{2,   3, -128,  3, 7, -88,   -88,    0};

        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            clear_model();
            exp_r[vt[v].hot] = vt[v].val;
            load_mem();
            run_pass(vt[v].tgt, lat, errv);
            check($sformatf("vec%0d done latency", v), lat, vt[v].exp_err != 0 ? 0 : NP + LAT);
            check($sformatf("vec%0d err", v), errv, vt[v].exp_err);
            clear_model();
            exp_r[vt[v].lo] = vt[v].exp_lo;
            exp_r[vt[v].hi] = vt[v].exp_hi;
            check_mem($sformatf("vec%0d", v));
        end

        // start during busy (with a new target) and in the done cycle are ignored;
        // start one cycle after done is accepted.
        clear_model();
        exp_r[0] = 16;
        load_mem();
        @(negedge clk);
        start = 1'b1; target = 0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; target = 1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, lat);
        check("seq first done latency", lat, NP + LAT);
        start = 1'b1; target = 2;
        @(posedge clk); #1;
        check("start in done cycle busy", int'(busy_o), 0);
        check("start in done cycle done", int'(done_o), 0);
        model_pass(0);
        check_mem("seq pass1");
        target = 1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start after done busy", int'(busy_o), 1);
        wait_done(0, lat);
        check("seq second done latency", lat, NP + LAT);
        @(posedge clk); #1;
        model_pass(1);
        check_mem("seq pass2");
        for (int i = 0; i < 4; i++) check($sformatf("two-pass amp[%0d]", i), int'(mem_r[i]), 7);

        // Asynchronous reset in the middle of the write phase.
        clear_model();
        exp_r[0] = 16;
        load_mem();
        @(negedge clk);
        start = 1'b1; target = 0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset wr_en", int'(ifc.wr_en), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-pass reset");
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        exp_r[4] = 16;
        exp_i[6] = -32;
        load_mem();
        run_pass(2, lat, errv);
        check("post-reset done latency", lat, NP + LAT);
        model_pass(2);
        check_mem("post-reset");

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < NA; i++) begin
                exp_r[i] = int'($urandom_range(0, 255)) - 128;
                exp_i[i] = int'($urandom_range(0, 255)) - 128;
            end
            load_mem();
            t = int'($urandom_range(0, 3));
            run_pass(t, lat, errv);
            check($sformatf("rand%0d done latency", r), lat, (t < NQ) ? NP + LAT : 0);
            check($sformatf("rand%0d err", r), errv, int'(t >= NQ));
            model_pass(t);
            check_mem($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
